// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, default widths and NOP control word for pipeline_stall_ctrl
package pipe_ctrl_pkg;

  // Cycle class; the encoding is visible on ctrl_state
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } ctrl_state_t;

  localparam int DEF_MAX_STALL = 4;
  localparam int DEF_CNT_W     = 3;
  localparam int DEF_PERF_W    = 32;

  // Control word carried by the pipeline registers; a NOP has every side effect off
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t NOP_CTRL = '{
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    branch:    1'b0,
    jump:      1'b0,
    alu_op:    4'd0
  };

  // Priority FREEZE > STALL > FLUSH > RUN; a completing memory access is not a freeze
  function automatic ctrl_state_t classify(input logic hazard, input logic branch,
                                           input logic mem_req, input logic mem_ready);
    return (mem_req & ~mem_ready) ? FREEZE :
           hazard                 ? STALL  :
           branch                 ? FLUSH  : RUN;
  endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter: free-running wrap-around cycle counter with enable and synchronous clear
module pipe_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise step when enabled and wrap naturally
  always_comb begin
    count_d = rst ? '0 : en ? count_q + 1'b1 : count_q;
  end

  // Counter register
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: pipeline enables, bubble/flush strobes and stall watchdog (perf counters under PIPE_PERF_CNT_EN)
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = DEF_MAX_STALL,
  parameter int CNT_W     = DEF_CNT_W
`ifdef PIPE_PERF_CNT_EN
  ,parameter int PERF_W   = DEF_PERF_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_timeout
`ifdef PIPE_PERF_CNT_EN
  ,output logic [PERF_W-1:0] perf_stall_cycles
  ,output logic [PERF_W-1:0] perf_flush_cycles
  ,output logic [PERF_W-1:0] perf_freeze_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TRIP    = CNT_W'(MAX_STALL - 1);

  ctrl_state_t      cls;
  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             stall_timeout_q, stall_timeout_d;

  // State, stall counter and sticky watchdog registers
  always_ff @(posedge clk) begin
    state_q         <= state_d;
    stall_count_q   <= stall_count_d;
    stall_timeout_q <= stall_timeout_d;
  end

  // Classify the current cycle and compute the next registered values
  always_comb begin
    cls             = classify(hazard_detected, branch_taken, mem_req, mem_ready);
    state_d         = rst ? RUN : cls;
    stall_count_d   = rst              ? '0 :
                      (cls == STALL)   ? ((stall_count_q == CNT_MAX) ? stall_count_q : stall_count_q + 1'b1) :
                      (cls == FREEZE)  ? stall_count_q : '0;
    stall_timeout_d = ~rst & (stall_timeout_q | ((cls == STALL) & (stall_count_q == TRIP)));
  end

  // Steering outputs follow the class with no latency; reset forces a pipeline clear
  always_comb begin
    pc_write_en    = ~rst & ((cls == RUN) | (cls == FLUSH));
    if_id_write_en = ~rst & ((cls == RUN) | (cls == FLUSH));
    if_id_flush    = rst | (cls == FLUSH);
    id_exe_bubble  = rst | (cls == STALL);
    pipe_freeze    = ~rst & (cls == FREEZE);
  end

  assign ctrl_state    = state_q;
  assign stall_count   = stall_count_q;
  assign stall_timeout = stall_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counter #(.W(PERF_W)) u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .en    (cls == STALL),
    .count (perf_stall_cycles)
  );

  pipe_perf_counter #(.W(PERF_W)) u_perf_flush (
    .clk   (clk),
    .rst   (rst),
    .en    (cls == FLUSH),
    .count (perf_flush_cycles)
  );

  pipe_perf_counter #(.W(PERF_W)) u_perf_freeze (
    .clk   (clk),
    .rst   (rst),
    .en    (cls == FREEZE),
    .count (perf_freeze_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed vectors with a queued scoreboard for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hazard_detected = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write_en, if_id_write_en, if_id_flush, id_exe_bubble, pipe_freeze;
  logic [1:0] ctrl_state;
  logic [2:0] stall_count;
  logic       stall_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_cycles, perf_freeze_cycles;
`endif

  pipeline_stall_ctrl #(.MAX_STALL(4), .CNT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .if_id_flush     (if_id_flush),
    .id_exe_bubble   (id_exe_bubble),
    .pipe_freeze     (pipe_freeze),
    .ctrl_state      (ctrl_state),
    .stall_count     (stall_count),
    .stall_timeout   (stall_timeout)
`ifdef PIPE_PERF_CNT_EN
    ,.perf_stall_cycles  (perf_stall_cycles)
    ,.perf_flush_cycles  (perf_flush_cycles)
    ,.perf_freeze_cycles (perf_freeze_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] steer;
    logic [1:0] st;
    logic [2:0] cnt;
    logic       to;
    logic       chk_perf;
    int         p_stall;
    int         p_flush;
    int         p_freeze;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Drive one cycle of inputs and queue the hand-computed response
  task automatic vec(input string name, input logic r, input logic hz, input logic br,
                     input logic mq, input logic mr, input logic [4:0] steer,
                     input logic [1:0] st, input logic [2:0] cnt, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    hazard_detected = hz;
    branch_taken = br;
    mem_req = mq;
    mem_ready = mr;
    e.name = name;
    e.steer = steer;
    e.st = st;
    e.cnt = cnt;
    e.to = to;
    e.chk_perf = 1'b0;
    e.p_stall = 0;
    e.p_flush = 0;
    e.p_freeze = 0;
    q.push_back(e);
  endtask

  // Monitor: outputs are valid mid-cycle, so compare at the falling edge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [4:0] act;
      e = q.pop_front();
      act = {pc_write_en, if_id_write_en, if_id_flush, id_exe_bubble, pipe_freeze};
      n_vec++;
      if (act !== e.steer || ctrl_state !== e.st || stall_count !== e.cnt || stall_timeout !== e.to) begin
        n_bad++;
        $display("FAIL %s: got steer=%b st=%0d cnt=%0d to=%b, need steer=%b st=%0d cnt=%0d to=%b",
                 e.name, act, ctrl_state, stall_count, stall_timeout, e.steer, e.st, e.cnt, e.to);
      end
`ifdef PIPE_PERF_CNT_EN
      if (e.chk_perf) begin
        n_vec++;
        if (perf_stall_cycles !== 32'(e.p_stall) || perf_flush_cycles !== 32'(e.p_flush) ||
            perf_freeze_cycles !== 32'(e.p_freeze)) begin
          n_bad++;
          $display("FAIL %s_perf: got %0d/%0d/%0d, need %0d/%0d/%0d", e.name, perf_stall_cycles,
                   perf_flush_cycles, perf_freeze_cycles, e.p_stall, e.p_flush, e.p_freeze);
        end
      end
`endif
    end
  end

  // steer bit order: {pc_write_en, if_id_write_en, if_id_flush, id_exe_bubble, pipe_freeze}
  localparam logic [4:0] S_RUN = 5'b11000;
  localparam logic [4:0] S_STL = 5'b00010;
  localparam logic [4:0] S_FLS = 5'b11100;
  localparam logic [4:0] S_FRZ = 5'b00001;
  localparam logic [4:0] S_RST = 5'b00110;

  initial begin
    @(posedge clk);
    vec("reset",          1, 0, 0, 0, 0, S_RST, 0, 0, 0);
    vec("run_after_rst",  0, 0, 0, 0, 0, S_RUN, 0, 0, 0);
    vec("stall1",         0, 1, 0, 0, 0, S_STL, 0, 0, 0);
    vec("stall2",         0, 1, 0, 0, 0, S_STL, 1, 1, 0);
    vec("stall_drop",     0, 0, 0, 0, 0, S_RUN, 1, 2, 0);
    vec("stall_cleared",  0, 0, 0, 0, 0, S_RUN, 0, 0, 0);
    vec("wd_stall1",      0, 1, 0, 0, 0, S_STL, 0, 0, 0);
    vec("wd_stall2",      0, 1, 0, 0, 0, S_STL, 1, 1, 0);
    vec("wd_stall3",      0, 1, 0, 0, 0, S_STL, 1, 2, 0);
    vec("wd_stall4",      0, 1, 0, 0, 0, S_STL, 1, 3, 0);
    vec("wd_tripped",     0, 0, 0, 0, 0, S_RUN, 1, 4, 1);
    vec("wd_sticky",      0, 0, 0, 0, 0, S_RUN, 0, 0, 1);
    vec("flush",          0, 0, 1, 0, 0, S_FLS, 0, 0, 1);
    vec("after_flush",    0, 0, 0, 0, 0, S_RUN, 2, 0, 1);
    vec("pre_freeze_stl", 0, 1, 0, 0, 0, S_STL, 0, 0, 1);
    vec("freeze1",        0, 1, 1, 1, 0, S_FRZ, 1, 1, 1);
    vec("freeze2",        0, 1, 1, 1, 0, S_FRZ, 3, 1, 1);
    vec("freeze3",        0, 1, 1, 1, 0, S_FRZ, 3, 1, 1);
    vec("mem_done_stall", 0, 1, 1, 1, 1, S_STL, 3, 1, 1);
    vec("after_mem_done", 0, 0, 0, 0, 0, S_RUN, 1, 2, 1);
    vec("sat1",           0, 1, 0, 0, 0, S_STL, 0, 0, 1);
    vec("sat2",           0, 1, 0, 0, 0, S_STL, 1, 1, 1);
    vec("sat3",           0, 1, 0, 0, 0, S_STL, 1, 2, 1);
    vec("sat4",           0, 1, 0, 0, 0, S_STL, 1, 3, 1);
    vec("sat5",           0, 1, 0, 0, 0, S_STL, 1, 4, 1);
    vec("sat6",           0, 1, 0, 0, 0, S_STL, 1, 5, 1);
    vec("sat7",           0, 1, 0, 0, 0, S_STL, 1, 6, 1);
    vec("sat8",           0, 1, 0, 0, 0, S_STL, 1, 7, 1);
    vec("sat_hold",       0, 0, 0, 0, 0, S_RUN, 1, 7, 1);
    vec("rst_in_stall",   1, 1, 0, 0, 0, S_RST, 0, 0, 1);
    vec("sticky_cleared", 0, 0, 0, 0, 0, S_RUN, 0, 0, 0);
    vec("mem_complete",   0, 0, 0, 1, 1, S_RUN, 0, 0, 0);
    vec("hz_and_br",      0, 1, 1, 0, 0, S_STL, 0, 0, 0);
    vec("after_hz_br",    0, 0, 0, 0, 0, S_RUN, 1, 1, 0);
    vec("perf_stall",     0, 1, 0, 0, 0, S_STL, 0, 0, 0);
    vec("perf_flush",     0, 0, 1, 0, 0, S_FLS, 1, 1, 0);
    vec("perf_frz1",      0, 0, 0, 1, 0, S_FRZ, 2, 0, 0);
    vec("perf_frz2",      0, 0, 0, 1, 0, S_FRZ, 3, 0, 0);
    vec("perf_frz3",      0, 0, 0, 1, 0, S_FRZ, 3, 0, 0);
    vec("perf_idle",      0, 0, 0, 0, 0, S_RUN, 3, 0, 0);
    q[q.size()-1].chk_perf = 1'b1;
    q[q.size()-1].p_stall  = 2;
    q[q.size()-1].p_flush  = 1;
    q[q.size()-1].p_freeze = 3;
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, need 0", q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
